// File: rtl/andor_seq_tester_if.sv
// Operand/result bus between the sequence tester and the 2-bit AND/OR stage.
// The tester drives the operands; the stage returns both results combinationally.
interface andor_seq_tester_if;
  logic [1:0] X;
  logic [1:0] Y;
  logic [1:0] XandY;
  logic [1:0] XorY;

  modport master (
    output X,
    output Y,
    input  XandY,
    input  XorY
  );

  modport slave (
    input  X,
    input  Y,
    output XandY,
    output XorY
  );
endinterface

// File: rtl/andor_seq_tester.sv
// Walks all 16 operand pairs through the AND/OR stage, holds each for SETTLE
// cycles, then checks both results and accumulates a saturating error count.
module andor_seq_tester #(
  parameter int SETTLE = 2,
  parameter int ERRW   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  andor_seq_tester_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRW-1:0]     errCount,
  output logic [3:0]          firstFail,
  output logic                failValid
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [ERRW-1:0] ERR_MAX     = '1;

  state_t          state;
  state_t          state_next;
  logic [3:0]      v;
  logic [3:0]      v_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic [ERRW-1:0] err_next;
  logic [3:0]      ffail_next;
  logic            fvalid_next;
  logic [1:0]      exp_and;
  logic [1:0]      exp_or;
  logic            mismatch;

  // Operands come straight from the index register, so in DONE they sit at 2'b11.
  assign bus.X = v[3:2];
  assign bus.Y = v[1:0];

  assign exp_and  = v[3:2] & v[1:0];
  assign exp_or   = v[3:2] | v[1:0];
  assign mismatch = (bus.XandY != exp_and) || (bus.XorY != exp_or);

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (errCount == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      v         <= '0;
      cnt       <= '0;
      errCount  <= '0;
      firstFail <= '0;
      failValid <= 1'b0;
    end else begin
      state     <= state_next;
      v         <= v_next;
      cnt       <= cnt_next;
      errCount  <= err_next;
      firstFail <= ffail_next;
      failValid <= fvalid_next;
    end
  end

  always_comb begin
    state_next  = state;
    v_next      = v;
    cnt_next    = cnt;
    err_next    = errCount;
    ffail_next  = firstFail;
    fvalid_next = failValid;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        // Results from the previous run are held until the next start clears them.
        if (start) begin
          v_next      = '0;
          cnt_next    = '0;
          err_next    = '0;
          ffail_next  = '0;
          fvalid_next = 1'b0;
          state_next  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_next   = '0;
          state_next = ST_CHECK;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (errCount != ERR_MAX) begin
            err_next = errCount + 1'b1;
          end
          if (!failValid) begin
            ffail_next  = v;
            fvalid_next = 1'b1;
          end
        end
        // The last vector finishes the run instead of wrapping the index.
        if (v == 4'd15) begin
          state_next = ST_DONE;
        end else begin
          v_next     = v + 4'd1;
          state_next = ST_SETTLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_andor_seq_tester.sv
// Directed bench: one tester with a switchable faulty AND/OR model, and a
// narrow-counter tester whose AND result is always stuck at 2'b11.
module tb_andor_seq_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int edgeCount = 0;
  int faultMode = 0;

  andor_seq_tester_if bus5 ();
  andor_seq_tester_if bus3 ();

  logic       busy5, done5, pass5, failValid5;
  logic [4:0] errCount5;
  logic [3:0] firstFail5;
  logic       busy3, done3, pass3, failValid3;
  logic [2:0] errCount3;
  logic [3:0] firstFail3;

  always #5 clk = ~clk;

  always @(posedge clk) edgeCount <= edgeCount + 1;

  always_comb begin
    bus5.XandY = bus5.X & bus5.Y;
    bus5.XorY  = (faultMode == 1) ? 2'b00 : (bus5.X | bus5.Y);
  end

  always_comb begin
    bus3.XandY = 2'b11;
    bus3.XorY  = bus3.X | bus3.Y;
  end

  andor_seq_tester #(.SETTLE(2), .ERRW(5)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus5.master),
    .busy      (busy5),
    .done      (done5),
    .pass      (pass5),
    .errCount  (errCount5),
    .firstFail (firstFail5),
    .failValid (failValid5)
  );

  andor_seq_tester #(.SETTLE(2), .ERRW(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus3.master),
    .busy      (busy3),
    .done      (done3),
    .pass      (pass3),
    .errCount  (errCount3),
    .firstFail (firstFail3),
    .failValid (failValid3)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge, which is edge k.
  task automatic applyStimulus(input int holdCycles, output int k);
    start = 1'b1;
    @(negedge clk);
    k = edgeCount;
    checkOutput("start busy", int'(busy5), 1);
    checkOutput("start done", int'(done5), 0);
    checkOutput("start XY", int'({bus5.X, bus5.Y}), 0);
    checkOutput("start errCount", int'(errCount5), 0);
    checkOutput("start failValid", int'(failValid5), 0);
    checkOutput("start firstFail", int'(firstFail5), 0);
    checkOutput("start errCount3", int'(errCount3), 0);
    checkOutput("start failValid3", int'(failValid3), 0);
    repeat (holdCycles - 1) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkRun(input int k, input int fromI, input int expErr, input int expFf,
                          input int expFv, input int expPass);
    for (int i = fromI; i < 16; i++) begin
      while (edgeCount < k + 3 * i) @(negedge clk);
      checkOutput($sformatf("vector %0d XY", i), int'({bus5.X, bus5.Y}), i);
    end
    while (edgeCount < k + 47) @(negedge clk);
    checkOutput("pre-done done", int'(done5), 0);
    checkOutput("pre-done busy", int'(busy5), 1);
    @(negedge clk);
    checkOutput("done edge", edgeCount - k, 48);
    checkOutput("done", int'(done5), 1);
    checkOutput("done busy", int'(busy5), 0);
    checkOutput("done XY", int'({bus5.X, bus5.Y}), 15);
    checkOutput("errCount", int'(errCount5), expErr);
    checkOutput("firstFail", int'(firstFail5), expFf);
    checkOutput("failValid", int'(failValid5), expFv);
    checkOutput("pass", int'(pass5), expPass);
    checkOutput("done3", int'(done3), 1);
    checkOutput("errCount3 saturated", int'(errCount3), 7);
    checkOutput("firstFail3", int'(firstFail3), 0);
    checkOutput("failValid3", int'(failValid3), 1);
    checkOutput("pass3", int'(pass3), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " XY"}, int'({bus5.X, bus5.Y}), 0);
    checkOutput({tag, " busy"}, int'(busy5), 0);
    checkOutput({tag, " done"}, int'(done5), 0);
    checkOutput({tag, " pass"}, int'(pass5), 0);
    checkOutput({tag, " errCount"}, int'(errCount5), 0);
    checkOutput({tag, " firstFail"}, int'(firstFail5), 0);
    checkOutput({tag, " failValid"}, int'(failValid5), 0);
    checkOutput({tag, " errCount3"}, int'(errCount3), 0);
    checkOutput({tag, " XY3"}, int'({bus3.X, bus3.Y}), 0);
  endtask

  initial begin
    int k;

    #2;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean run, start accepted at edge 10 so done lands on edge 58.
    while (edgeCount < 9) @(negedge clk);
    faultMode = 0;
    applyStimulus(1, k);
    checkOutput("first start edge", k, 10);
    checkRun(k, 1, 0, 0, 0, 1);

    // Results hold in DONE while start stays low.
    repeat (4) @(negedge clk);
    checkOutput("hold done", int'(done5), 1);
    checkOutput("hold pass", int'(pass5), 1);

    // XorY stuck at zero: every vector but 0 mismatches.
    faultMode = 1;
    applyStimulus(1, k);
    checkRun(k, 1, 15, 1, 1, 0);

    // Restart from a failing DONE with the fault removed, start held 20 cycles.
    faultMode = 0;
    applyStimulus(20, k);
    checkOutput("held start XY", int'({bus5.X, bus5.Y}), 6);
    checkOutput("held start busy", int'(busy5), 1);
    checkOutput("held start errCount", int'(errCount5), 0);
    checkOutput("held start errCount3", int'(errCount3), 6);
    checkRun(k, 7, 0, 0, 0, 1);

    // Asynchronous reset between edges while vector 7 is presented.
    faultMode = 1;
    applyStimulus(1, k);
    while (edgeCount < k + 21) @(negedge clk);
    checkOutput("mid-run XY", int'({bus5.X, bus5.Y}), 7);
    checkOutput("mid-run errCount", int'(errCount5), 6);
    checkOutput("mid-run firstFail", int'(firstFail5), 1);
    checkOutput("mid-run errCount3", int'(errCount3), 7);
    #1 rst_n = 1'b0;
    #1;
    checkAllZero("async reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    faultMode = 0;
    repeat (5) @(negedge clk);
    checkAllZero("post reset idle");

    applyStimulus(1, k);
    checkRun(k, 1, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/andor_seq_tester.md
# andor_seq_tester

Clocked stimulus generator and response checker for the 2-bit AND/OR stage. It drives the `X`/`Y` operand buses into the AND/OR block and consumes its `XandY`/`XorY` results. It walks all 16 operand combinations, waits a programmable settle time, and compares each result against the expected value. It reports an error count, the first failing vector and pass/fail through a start/done handshake.

## Interface
- `SETTLE`, default 2: cycles each vector is held before its result is sampled; legal range 1..15.
- `ERRW`, default 5: width of the saturating error counter; minimum 3.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  level sampled each edge; accepted only in IDLE or DONE.
- `X`  out  2  operand X to the AND/OR stage (registered).
- `Y`  out  2  operand Y to the AND/OR stage (registered).
- `XandY`  in  2  AND result from the AND/OR stage.
- `XorY`  in  2  OR result from the AND/OR stage.
- `busy`  out  1  high from the edge that accepts `start` until the edge entering DONE.
- `done`  out  1  high while in DONE.
- `pass`  out  1  high in DONE when `errCount` == 0; otherwise 0.
- `errCount`  out  ERRW  number of mismatching vectors in the current or last run; saturates at all-ones.
- `firstFail`  out  4  {X,Y} of the first mismatching vector in the run.
- `failValid`  out  1  `firstFail` holds a captured vector.

## Operation
- Internal state:
  - 4-bit vector index `v`, with `X` = `v[3:2]` and `Y` = `v[1:0]`. `X`/`Y` come straight from the `v` register, with no extra stage.
  - 4-bit settle counter `cnt`.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - `busy`=0, `done`=0.
  - On `start`=1: `v`←0, `cnt`←0, `errCount`←0, `failValid`←0, `firstFail`←0, go to SETTLE.
- SETTLE:
  - `cnt` increments each edge.
  - When `cnt` == SETTLE-1: `cnt`←0, go to CHECK. Each vector therefore spends exactly SETTLE cycles in SETTLE.
- CHECK, one cycle. Mismatch means `XandY` != (`X`&`Y`) or `XorY` != (`X`|`Y`).
  - On mismatch: `errCount`←`errCount`+1 unless it is all-ones. If `failValid`=0, then `firstFail`←{`X`,`Y`} and `failValid`←1.
  - If `v` == 15, go to DONE. Otherwise `v`←`v`+1 and go to SETTLE.
  - Each vector costs SETTLE+1 cycles.
- DONE:
  - `done`=1, `busy`=0, `pass`=(`errCount`==0).
  - `X`/`Y` hold 2'b11.
  - Results stay stable until `start`=1. That edge performs the same clearing as in IDLE and enters SETTLE.
- `start` in SETTLE or CHECK is ignored; no restart and no effect on counters.
- Reset mid-run: the run is abandoned immediately with no partial result retained.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - state = IDLE.
  - `X`=`Y`=0, `v`=0, `cnt`=0.
  - `busy`=0, `done`=0, `pass`=0.
  - `errCount`=0, `firstFail`=0, `failValid`=0.
- Start acceptance:
  - Start accepted at edge k: `busy`=1 and `X`=`Y`=0 from edge k.
  - DONE is entered at edge k + 16·(SETTLE+1); with SETTLE=2 that is k+48.
  - `done` rises and `busy` falls at that same edge.
- Result sampling:
  - The vector with index `v` is presented from the edge it is loaded.
  - Its result is sampled at the edge leaving CHECK, SETTLE+1 edges later.
  - The AND/OR stage is combinational, so sampling latency is SETTLE+1 cycles.
- Counter updates:
  - `errCount` and `firstFail` update at the CHECK exit edge.
  - `pass` is combinational from state and `errCount`.
- Boundaries:
  - `v` never wraps during a run; the 15→DONE transition replaces the increment.
  - `errCount` saturation holds at 2^ERRW−1.

## Test plan
- Correct AND/OR stage, SETTLE=2, `start` pulse at cycle 10 → `X`/`Y` step through 0..15 every 3 cycles; `done`=1 at edge 58; `pass`=1, `errCount`=0, `failValid`=0.
- `XorY` stuck at 2'b00 → 15 mismatches (all vectors except 0); `errCount`=15, `firstFail`=4'b0001, `failValid`=1, `pass`=0.
- ERRW=3, `XandY` forced to 2'b11 → 15 mismatches expected but `errCount` saturates at 7; `firstFail`=4'b0000.
- `start` held high for 20 cycles during a run → no restart; `done` at the same edge as with a single pulse; counters unaffected.
- `rst_n` pulsed low mid-run at vector 7 (asynchronous, between edges) → all outputs 0 immediately; no activity until the next `start`; a subsequent run completes normally.
- Second `start` while in DONE after a failing run with the fault removed → `errCount`, `failValid` and `firstFail` cleared at the start edge; run ends with `pass`=1.
